// File: rtl/eth_tx_sched_pkg.sv
// Shared types and helpers for the 10G Ethernet transmit-path packet scheduler.
// Widths here are upper bounds; callers truncate to their own parameters.
package eth_tx_sched_pkg;

    localparam int MAX_CH    = 32;
    localparam int MAX_LVL_W = 8;
    localparam int REQ_W     = MAX_CH * MAX_LVL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    function automatic logic [MAX_CH-1:0] onehot(input int idx);
        logic [MAX_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Request field of channel c, lvl_w bits wide, zero-extended.
    function automatic logic [MAX_LVL_W-1:0] level_of(input logic [REQ_W-1:0] req,
                                                     input int c, input int lvl_w);
        logic [MAX_LVL_W-1:0] mask;
        mask = MAX_LVL_W'((1 << lvl_w) - 1);
        return MAX_LVL_W'(req >> (c * lvl_w)) & mask;
    endfunction

endpackage

// File: rtl/eth_tx_rr_pick.sv
// Combinational winner select: highest level wins, ties resolved round-robin
// starting one above the last winner.
module eth_tx_rr_pick #(
    parameter int CHANNEL_QTY = 4,
    parameter int ARBIT_LEVEL = 2,
    parameter int IDX_W       = 2
) (
    input  logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] levels,
    input  logic [IDX_W-1:0]                   rr_ptr,
    output logic [IDX_W-1:0]                   winner,
    output logic                               found
);

    always_comb begin
        logic [ARBIT_LEVEL-1:0] best;
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned, which would infer a latch.
        best   = '0;
        winner = rr_ptr;
        idx    = 0;
        // Strict '>' keeps the first channel met in round-robin order among equals.
        for (int k = 1; k <= CHANNEL_QTY; k++) begin
            idx = (int'(rr_ptr) + k) % CHANNEL_QTY;
            if (levels[idx*ARBIT_LEVEL +: ARBIT_LEVEL] > best) begin
                best   = levels[idx*ARBIT_LEVEL +: ARBIT_LEVEL];
                winner = IDX_W'(idx);
            end
        end
        found = (best != '0);
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Packet-level scheduler for the shared 10G transmit path: one whole-packet grant
// at a time, switch guard after each packet, starvation aging and a grant watchdog.
module eth_tx_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int CHANNEL_QTY   = 4,
    parameter int ARBIT_LEVEL   = 2,
    parameter int MUX_SW_DELAY  = 2,
    parameter int AGE_LIMIT     = 1024,
    parameter int GRANT_TIMEOUT = 65535,
    localparam int IDX_W        = (CHANNEL_QTY > 1) ? $clog2(CHANNEL_QTY) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] arbit_request,
    input  logic [CHANNEL_QTY-1:0]             arbit_eop,
    output logic [CHANNEL_QTY-1:0]             arbit_grant,
    output logic [IDX_W-1:0]                   mux_sel,
    output logic                               grant_valid,
    output logic                               timeout_err
);

    localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam int WD_W  = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam int GD_W  = (MUX_SW_DELAY > 0) ? $clog2(MUX_SW_DELAY + 1) : 1;
    localparam logic [ARBIT_LEVEL-1:0] MAX_LVL = '1;

    state_t                             state;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [AGE_W-1:0]                   age [CHANNEL_QTY];
    logic [WD_W-1:0]                    wd;
    logic [GD_W-1:0]                    guard_cnt;
    logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] eff_levels;
    logic [CHANNEL_QTY-1:0]             req_active;
    logic [IDX_W-1:0]                   pick_idx;
    logic                               pick_found;
    logic                               granted_eop;
    logic                               wd_expired;
    logic                               guard_done;

    // A channel that has waited AGE_LIMIT cycles competes at the top level.
    always_comb begin
        eff_levels = '0;
        req_active = '0;
        for (int c = 0; c < CHANNEL_QTY; c++) begin
            eff_levels[c*ARBIT_LEVEL +: ARBIT_LEVEL] =
                ARBIT_LEVEL'(level_of(REQ_W'(arbit_request), c, ARBIT_LEVEL));
            req_active[c] = (eff_levels[c*ARBIT_LEVEL +: ARBIT_LEVEL] != '0);
            if (AGE_LIMIT != 0 && req_active[c] && age[c] == AGE_W'(AGE_LIMIT))
                eff_levels[c*ARBIT_LEVEL +: ARBIT_LEVEL] = MAX_LVL;
        end
    end

    eth_tx_rr_pick #(
        .CHANNEL_QTY (CHANNEL_QTY),
        .ARBIT_LEVEL (ARBIT_LEVEL),
        .IDX_W       (IDX_W)
    ) u_pick (
        .levels (eff_levels),
        .rr_ptr (rr_ptr),
        .winner (pick_idx),
        .found  (pick_found)
    );

    // Only the owner's eop can end the packet; other sources' eops are ignored.
    assign granted_eop = |(arbit_eop & arbit_grant);
    assign wd_expired  = (GRANT_TIMEOUT != 0) && (wd == WD_W'(GRANT_TIMEOUT - 1));
    assign guard_done  = (guard_cnt == GD_W'(MUX_SW_DELAY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            arbit_grant <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            mux_sel     <= '0;
            rr_ptr      <= '0;
            wd          <= '0;
            guard_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        arbit_grant <= CHANNEL_QTY'(onehot(int'(pick_idx)));
                        grant_valid <= 1'b1;
                        mux_sel     <= pick_idx;
                        rr_ptr      <= pick_idx;
                        wd          <= '0;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A real eop wins over a watchdog expiry landing on the same edge.
                    if (granted_eop || wd_expired) begin
                        arbit_grant <= '0;
                        grant_valid <= 1'b0;
                        timeout_err <= !granted_eop;
                        guard_cnt   <= '0;
                        state       <= (MUX_SW_DELAY == 0) ? ST_IDLE : ST_GUARD;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (guard_done) state <= ST_IDLE;
                    else            guard_cnt <= guard_cnt + GD_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the age array is a handful of flops feeding the arbiter, so unlike a RAM it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNEL_QTY; c++) age[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNEL_QTY; c++) begin
                if (!req_active[c] || arbit_grant[c])
                    age[c] <= '0;
                else if (age[c] != AGE_W'(AGE_LIMIT))
                    age[c] <= age[c] + AGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: a packet-level reference model predicts grant,
// release and timeout events; an independent monitor matches them against the DUT.
module tb_eth_tx_sched;

    localparam int CH   = 4;
    localparam int LW   = 2;
    localparam int DLY  = 2;
    localparam int AGE  = 8;
    localparam int TO   = 16;
    localparam int MAXL = (1 << LW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*LW-1:0]  arbit_request;
    logic [CH-1:0]     arbit_eop;
    logic [CH-1:0]     arbit_grant;
    logic [1:0]        mux_sel;
    logic              grant_valid;
    logic              timeout_err;

    eth_tx_sched #(
        .CHANNEL_QTY   (CH),
        .ARBIT_LEVEL   (LW),
        .MUX_SW_DELAY  (DLY),
        .AGE_LIMIT     (AGE),
        .GRANT_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arbit_request (arbit_request),
        .arbit_eop     (arbit_eop),
        .arbit_grant   (arbit_grant),
        .mux_sel       (mux_sel),
        .grant_valid   (grant_valid),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef enum int {EV_GRANT, EV_RELEASE, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       ch;
        int       cyc;
    } ev_t;
    ev_t sb[$];

    // Packet-level reference model: who owns the link, for how long, and when
    // arbitration is allowed again.
    int m_owner;
    int m_held;
    int m_free_at;
    int m_rr;
    int m_age [CH];

    function automatic int lvl(input logic [CH*LW-1:0] r, input int c);
        return int'(r[c*LW +: LW]);
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_free_at = 0;
        m_rr      = 0;
        for (int c = 0; c < CH; c++) m_age[c] = 0;
    endtask

    // Predicts what the clock edge numbered t does with these inputs.
    task automatic model_edge(input logic [CH*LW-1:0] req, input logic [CH-1:0] eop, input int t);
        int prev_owner;
        int eff [CH];
        int top;
        int win;
        prev_owner = m_owner;
        if (m_owner >= 0) begin
            if (eop[m_owner]) begin
                sb.push_back('{EV_RELEASE, m_owner, t});
                m_owner   = -1;
                m_free_at = t + DLY + 1;
            end else begin
                m_held++;
                if (m_held == TO) begin
                    sb.push_back('{EV_TIMEOUT, m_owner, t});
                    sb.push_back('{EV_RELEASE, m_owner, t});
                    m_owner   = -1;
                    m_free_at = t + DLY + 1;
                end
            end
        end else if (t >= m_free_at) begin
            top = 0;
            for (int c = 0; c < CH; c++) begin
                eff[c] = lvl(req, c);
                if (eff[c] != 0 && m_age[c] == AGE) eff[c] = MAXL;
                if (eff[c] > top) top = eff[c];
            end
            if (top > 0) begin
                win = -1;
                for (int k = 1; k <= CH; k++) begin
                    if (win < 0 && eff[(m_rr + k) % CH] == top) win = (m_rr + k) % CH;
                end
                sb.push_back('{EV_GRANT, win, t});
                m_owner = win;
                m_held  = 0;
                m_rr    = win;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (lvl(req, c) == 0 || prev_owner == c) m_age[c] = 0;
            else if (m_age[c] < AGE)                m_age[c]++;
        end
    endtask

    // Monitor: turns DUT output changes into events and matches them in order.
    logic          prev_valid = 1'b0;
    int            exp_sel    = 0;
    logic [CH-1:0] exp_grant  = '0;

    task automatic expect_event(input ev_kind_t k);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event at cycle %0d: got %s on ch %0d, expected none",
                     cyc, k.name(), mux_sel);
        end else begin
            e = sb.pop_front();
            check($sformatf("event_kind(%s)", e.kind.name()), k, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_channel", mux_sel, e.ch);
            if (e.kind == EV_GRANT) begin
                exp_sel   = e.ch;
                exp_grant = CH'(1 << e.ch);
            end else if (e.kind == EV_RELEASE) begin
                exp_grant = '0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            exp_sel    = 0;
            exp_grant  = '0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check($sformatf("missed_%s_cycle", sb[0].kind.name()), cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (timeout_err)                 expect_event(EV_TIMEOUT);
            if (prev_valid && !grant_valid)  expect_event(EV_RELEASE);
            if (!prev_valid && grant_valid)  expect_event(EV_GRANT);
            check("arbit_grant", arbit_grant, exp_grant);
            check("mux_sel", mux_sel, exp_sel);
            prev_valid = grant_valid;
        end
    end

    task automatic drive(input logic [CH*LW-1:0] req, input logic [CH-1:0] eop);
        @(negedge clk);
        arbit_request = req;
        arbit_eop     = eop;
        model_edge(req, eop, cyc + 1);
    endtask

    // eop_after < 0: never end the owner's packet; foreign: random eop on a non-owner.
    task automatic run(input logic [CH*LW-1:0] req, input int cycles, input int eop_after,
                       input bit foreign);
        logic [CH-1:0] e;
        for (int i = 0; i < cycles; i++) begin
            e = '0;
            if (foreign) e[$urandom_range(0, CH-1)] = 1'b1;
            if (m_owner >= 0) begin
                if (foreign) e[m_owner] = 1'b0;
                if (eop_after >= 0 && m_held >= eop_after) e[m_owner] = 1'b1;
            end
            drive(req, e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, arbit_grant, 0);
        check({tag, "_grant_valid"}, grant_valid, 0);
        check({tag, "_mux_sel"}, mux_sel, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        arbit_request = '0;
        arbit_eop     = '0;
        rst_n         = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit at cycle %0d: bench did not finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [CH*LW-1:0] req;
        logic [CH-1:0]    e;
        rst_n         = 1'b0;
        arbit_request = '0;
        arbit_eop     = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        run('0, 4, -1, 1'b0);
        // Sole requester ch2 at level 1, two packets separated by the guard.
        run(8'b00_01_00_00, 30, 8, 1'b0);
        run('0, 6, 0, 1'b0);
        // Foreign eop and withdrawn request must not release ch1.
        run(8'b00_00_10_00, 3, -1, 1'b0);
        run('0, 6, -1, 1'b1);
        run('0, 4, 0, 1'b0);
        // Watchdog: ch3 never ends its packet.
        run(8'b11_00_00_00, 40, -1, 1'b0);
        // Reset while ch0 holds the link.
        run(8'b00_00_00_01, 5, -1, 1'b0);
        mid_reset("mid_grant");
        // Priority with aging from rr_ptr 0: ch1 is eventually promoted.
        run(8'b11_00_01_11, 120, 2, 1'b0);
        run('0, 6, 0, 1'b0);

        req = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) mid_reset("random");
            if ($urandom_range(0, 7) == 0) req = (CH*LW)'($urandom);
            e = '0;
            if ($urandom_range(0, 3) == 0) e[$urandom_range(0, CH-1)] = 1'b1;
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) e[m_owner] = 1'b1;
            drive(req, e);
        end
        run('0, 30, 0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
